morse_seq: RTL

MORSE_SEQ -- requirements
Module: morse_seq

---
 rtl/morse_seq.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/morse_seq.sv
`default_nettype none
// ============================================================================
// Module      : morse_seq
// Description : Programmable Morse keyer. Executes DIT/DAH/SPACE/END words
//               from a small write-only program memory and keys `emitter`.
// Revision    : 1.0 - initial release
// ============================================================================
module morse_seq #(
    parameter int DEPTH       = 256,
    parameter int UNIT_CYCLES = 50000000,
    parameter int DAH_UNITS   = 3,
    parameter int AUTO_GAP    = 1,
    parameter int AW          = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          start,
    input  logic          stop,
    input  logic          loop,
    output logic          busy,
    output logic          done,
    output logic          emitter,
    output logic [AW-1:0] pc
);

    localparam int TW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [TW-1:0] c_TICK_LAST = TW'(UNIT_CYCLES - 1);
    localparam logic [5:0]    c_DAH_LAST  = 6'(DAH_UNITS - 1);

    localparam logic [1:0] c_OP_SPACE = 2'b00;
    localparam logic [1:0] c_OP_DAH   = 2'b01;
    localparam logic [1:0] c_OP_DIT   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_MARK  = 3'd2,
        S_GAP   = 3'd3,
        S_SPACE = 3'd4
    } state_t;

    // Power-up contents are END so an unprogrammed run terminates at once.
    logic [7:0] r_mem [DEPTH] = '{default: 8'hC0};

    state_t        r_state;
    state_t        w_next_state;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] w_next_pc;
    logic [TW-1:0] r_tick;
    logic [TW-1:0] w_next_tick;
    logic [5:0]    r_units;
    logic [5:0]    w_next_units;
    logic          r_done;
    logic          w_next_done;
    logic          r_emitter;

    logic [7:0]    w_instr;
    logic          w_unit_end;
    logic          w_wr_accept;

    assign w_instr     = r_mem[r_pc];
    assign w_unit_end  = (r_tick == c_TICK_LAST);
    assign w_wr_accept = wr_en && !rst && (r_state == S_IDLE);

    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_tick    <= '0;
            r_units   <= '0;
            r_done    <= 1'b0;
            r_emitter <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_pc      <= w_next_pc;
            r_tick    <= w_next_tick;
            r_units   <= w_next_units;
            r_done    <= w_next_done;
            r_emitter <= (w_next_state == S_MARK);
        end
    end

    // r_units holds the remaining unit count minus one for the current segment.
    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_next_tick  = r_tick;
        w_next_units = r_units;
        w_next_done  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_FETCH;
                    w_next_pc    = '0;
                end
            end
            S_FETCH: begin
                w_next_tick = '0;
                case (w_instr[7:6])
                    c_OP_DIT: begin
                        w_next_state = S_MARK;
                        w_next_units = 6'd0;
                        w_next_pc    = r_pc + 1'b1;
                    end
                    c_OP_DAH: begin
                        w_next_state = S_MARK;
                        w_next_units = c_DAH_LAST;
                        w_next_pc    = r_pc + 1'b1;
                    end
                    c_OP_SPACE: begin
                        w_next_state = S_SPACE;
                        w_next_units = w_instr[5:0];
                        w_next_pc    = r_pc + 1'b1;
                    end
                    default: begin
                        if (loop) begin
                            w_next_state = S_FETCH;
                            w_next_pc    = '0;
                        end else begin
                            w_next_state = S_IDLE;
                            w_next_done  = 1'b1;
                        end
                    end
                endcase
            end
            S_MARK, S_GAP, S_SPACE: begin
                if (w_unit_end) begin
                    w_next_tick = '0;
                    if (r_units == 6'd0) begin
                        if (r_state == S_MARK && AUTO_GAP != 0) begin
                            w_next_state = S_GAP;
                        end else begin
                            w_next_state = S_FETCH;
                        end
                    end else begin
                        w_next_units = r_units - 6'd1;
                    end
                end else begin
                    w_next_tick = r_tick + 1'b1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        if (stop) begin
            w_next_state = S_IDLE;
            w_next_pc    = '0;
            w_next_tick  = '0;
            w_next_units = '0;
            w_next_done  = 1'b0;
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;
    assign emitter = r_emitter;
    assign pc      = r_pc;

endmodule
`default_nettype wire
